// File: rtl/rob_multi_commit_pkg.sv
// Shared types and constants for the multi-commit reorder buffer.
package rob_multi_commit_pkg;
  localparam int XLEN     = 32;
  localparam int TAG_NONE = 0;

  // Per-entry payload; the destination register lives in its own array because its width is a module parameter.
  typedef struct packed {
    logic            is_store;
    logic            is_branch;
    logic [XLEN-1:0] pred_pc;
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] value;
  } rob_entry_t;
endpackage

// File: rtl/rob_multi_commit_sel.sv
// In-order retire chain over the head window, plus flush/redirect from a mispredicted branch.
// Combinational; a store or branch in a slot stops younger slots from retiring that cycle.
module rob_multi_commit_sel #(
  parameter int COMMIT_WIDTH = 2
) (
  input  logic                     rdy_in,
  input  logic [COMMIT_WIDTH-1:0]  slot_vld,
  input  logic [COMMIT_WIDTH-1:0]  slot_done,
  input  logic [COMMIT_WIDTH-1:0]  slot_store,
  input  logic [COMMIT_WIDTH-1:0]  slot_branch,
  input  logic [COMMIT_WIDTH-1:0]  slot_mispred,
  input  logic [COMMIT_WIDTH*32-1:0] slot_npc,
  output logic [COMMIT_WIDTH-1:0]  commit_valid,
  output logic [COMMIT_WIDTH-1:0]  commit_wr_reg,
  output logic                     commit_store,
  output logic                     flush_out,
  output logic [31:0]              redirect_pc
);
  logic go;

  always_comb begin
    commit_valid  = '0;
    commit_wr_reg = '0;
    commit_store  = 1'b0;
    flush_out     = 1'b0;
    redirect_pc   = '0;
    go            = rdy_in;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      go              = go & slot_vld[k] & slot_done[k];
      commit_valid[k] = go;
      if (go) begin
        commit_wr_reg[k] = !slot_store[k] && !slot_branch[k];
        if (slot_store[k]) commit_store = 1'b1;
        if (slot_branch[k] && slot_mispred[k]) begin
          flush_out   = 1'b1;
          redirect_pc = slot_npc[k*32 +: 32];
        end
      end
      go = go & !slot_store[k] & !slot_branch[k];
    end
  end
endmodule

// File: rtl/rob_multi_commit.sv
// Reorder buffer: one alloc/cycle, WB_PORTS writebacks, up to COMMIT_WIDTH in-order retires/cycle.
// WB to head retires next cycle; issue_ready from registered count; rdy_in low freezes all state.
module rob_multi_commit #(
  parameter int Q_WIDTH        = 4,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int WB_PORTS       = 2,
  parameter int COMMIT_WIDTH   = 2
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               rdy_in,
  input  logic                               issue_valid,
  output logic                               issue_ready,
  input  logic                               issue_is_store,
  input  logic                               issue_is_branch,
  input  logic [REG_ADDR_WIDTH-1:0]          issue_rd,
  input  logic [31:0]                        issue_pc,
  input  logic [31:0]                        issue_pred_pc,
  output logic [Q_WIDTH-1:0]                 alloc_tag,
  input  logic [WB_PORTS-1:0]                wb_valid,
  input  logic [WB_PORTS*Q_WIDTH-1:0]        wb_tag,
  input  logic [WB_PORTS*32-1:0]             wb_value,
  input  logic [WB_PORTS*32-1:0]             wb_npc,
  input  logic [2*Q_WIDTH-1:0]               rd_tag,
  output logic [1:0]                         rd_has_value,
  output logic [63:0]                        rd_value,
  output logic [COMMIT_WIDTH-1:0]            commit_valid,
  output logic [COMMIT_WIDTH*Q_WIDTH-1:0]    commit_tag,
  output logic [COMMIT_WIDTH*REG_ADDR_WIDTH-1:0] commit_rd,
  output logic [COMMIT_WIDTH*32-1:0]         commit_value,
  output logic [COMMIT_WIDTH-1:0]            commit_wr_reg,
  output logic                               commit_store,
  output logic                               flush_out,
  output logic [31:0]                        redirect_pc,
  output logic [Q_WIDTH-1:0]                 count
);
  import rob_multi_commit_pkg::*;

  localparam int DEPTH = 2**Q_WIDTH - 1;
  localparam int SLOTS = 2**Q_WIDTH;

  rob_entry_t                ent    [SLOTS];
  logic [REG_ADDR_WIDTH-1:0] ent_rd [SLOTS];
  logic [SLOTS-1:0]          ent_vld, ent_done;
  logic [Q_WIDTH-1:0]        head, tail, cnt, head_nxt, n_ret;
  logic [Q_WIDTH-1:0]        slot_ptr [COMMIT_WIDTH+1];
  logic [COMMIT_WIDTH-1:0]   s_vld, s_done, s_store, s_branch, s_mispred;
  logic [COMMIT_WIDTH*32-1:0] s_npc;
  logic [WB_PORTS-1:0]       wb_hit;
  logic                      alloc;
  logic                      unused_pc;

  // Index 0 is the "no rename" tag, so the ring skips it.
  function automatic logic [Q_WIDTH-1:0] ptr_inc(input logic [Q_WIDTH-1:0] p);
    return (p == Q_WIDTH'(DEPTH)) ? Q_WIDTH'(1) : p + 1'b1;
  endfunction

  assign unused_pc   = ^issue_pc;
  assign issue_ready = (cnt != Q_WIDTH'(DEPTH));
  assign alloc_tag   = tail;
  assign count       = cnt;
  assign alloc       = issue_valid && issue_ready && rdy_in && !flush_out;

  always_comb begin
    slot_ptr[0] = head;
    for (int k = 1; k <= COMMIT_WIDTH; k++) slot_ptr[k] = ptr_inc(slot_ptr[k-1]);
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      s_vld[k]            = ent_vld[slot_ptr[k]];
      s_done[k]           = ent_done[slot_ptr[k]];
      s_store[k]          = ent[slot_ptr[k]].is_store;
      s_branch[k]         = ent[slot_ptr[k]].is_branch;
      s_mispred[k]        = ent[slot_ptr[k]].npc != ent[slot_ptr[k]].pred_pc;
      s_npc[k*32 +: 32]   = ent[slot_ptr[k]].npc;
    end
  end

  rob_multi_commit_sel #(.COMMIT_WIDTH(COMMIT_WIDTH)) u_sel (
    .rdy_in       (rdy_in),
    .slot_vld     (s_vld),
    .slot_done    (s_done),
    .slot_store   (s_store),
    .slot_branch  (s_branch),
    .slot_mispred (s_mispred),
    .slot_npc     (s_npc),
    .commit_valid (commit_valid),
    .commit_wr_reg(commit_wr_reg),
    .commit_store (commit_store),
    .flush_out    (flush_out),
    .redirect_pc  (redirect_pc)
  );

  always_comb begin
    commit_tag   = '0;
    commit_rd    = '0;
    commit_value = '0;
    n_ret        = '0;
    head_nxt     = head;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (commit_valid[k]) begin
        commit_tag[k*Q_WIDTH +: Q_WIDTH]               = slot_ptr[k];
        commit_rd[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]  = ent_rd[slot_ptr[k]];
        commit_value[k*32 +: 32]                       = ent[slot_ptr[k]].value;
      end
      n_ret = n_ret + Q_WIDTH'(commit_valid[k]);
    end
    for (int k = 0; k <= COMMIT_WIDTH; k++)
      if (n_ret == Q_WIDTH'(k)) head_nxt = slot_ptr[k];
  end

  always_comb begin
    for (int i = 0; i < WB_PORTS; i++)
      wb_hit[i] = wb_valid[i] && (wb_tag[i*Q_WIDTH +: Q_WIDTH] != Q_WIDTH'(TAG_NONE))
                  && ent_vld[wb_tag[i*Q_WIDTH +: Q_WIDTH]];
  end

  // Stored value beats bypass; among bypasses the lowest channel wins.
  always_comb begin
    rd_has_value = '0;
    rd_value     = '0;
    for (int j = 0; j < 2; j++) begin
      if (rd_tag[j*Q_WIDTH +: Q_WIDTH] != Q_WIDTH'(TAG_NONE)) begin
        for (int i = WB_PORTS-1; i >= 0; i--) begin
          if (wb_valid[i] && wb_tag[i*Q_WIDTH +: Q_WIDTH] == rd_tag[j*Q_WIDTH +: Q_WIDTH]) begin
            rd_has_value[j]     = 1'b1;
            rd_value[j*32 +: 32] = wb_value[i*32 +: 32];
          end
        end
        if (ent_done[rd_tag[j*Q_WIDTH +: Q_WIDTH]]) begin
          rd_has_value[j]     = 1'b1;
          rd_value[j*32 +: 32] = ent[rd_tag[j*Q_WIDTH +: Q_WIDTH]].value;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head     <= Q_WIDTH'(1);
      tail     <= Q_WIDTH'(1);
      cnt      <= '0;
      ent_vld  <= '0;
      ent_done <= '0;
    end else if (rdy_in) begin
      if (flush_out) begin
        head     <= Q_WIDTH'(1);
        tail     <= Q_WIDTH'(1);
        cnt      <= '0;
        ent_vld  <= '0;
        ent_done <= '0;
      end else begin
        for (int i = WB_PORTS-1; i >= 0; i--) begin
          if (wb_hit[i]) begin
            ent_done[wb_tag[i*Q_WIDTH +: Q_WIDTH]]       <= 1'b1;
            ent[wb_tag[i*Q_WIDTH +: Q_WIDTH]].value      <= wb_value[i*32 +: 32];
            ent[wb_tag[i*Q_WIDTH +: Q_WIDTH]].npc        <= wb_npc[i*32 +: 32];
          end
        end
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
          if (commit_valid[k]) begin
            ent_vld[slot_ptr[k]]  <= 1'b0;
            ent_done[slot_ptr[k]] <= 1'b0;
          end
        end
        if (alloc) begin
          ent_vld[tail]           <= 1'b1;
          ent_done[tail]          <= 1'b0;
          ent[tail].is_store      <= issue_is_store;
          ent[tail].is_branch     <= issue_is_branch;
          ent[tail].pred_pc       <= issue_pred_pc;
          ent_rd[tail]            <= issue_rd;
          tail                    <= ptr_inc(tail);
        end
        head <= head_nxt;
        cnt  <= cnt + Q_WIDTH'(alloc) - n_ret;
      end
    end
  end
endmodule
